// File: rtl/paritysel_pkg.sv
// Shared constants and types for the parity-select burst sequencer.
// SEL_W sizes both the select value and the remaining-beat counter.
package paritysel_pkg;

    localparam int unsigned SEL_W = 5;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [SEL_W-1:0] beat_cnt_t;

    // Low bit of sel tells the downstream mux to pick operand B.
    function automatic logic pick_b(input sel_t sel_v);
        return sel_v[0];
    endfunction

endpackage

// File: rtl/paritysel_seq.sv
// Burst sequencer: accepts one request (operands, start select, length) and
// emits len+1 beats with an incrementing select value under valid/ready flow control.
module paritysel_seq
    import paritysel_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data_a,
    input  logic [WIDTH-1:0] in_data_b,
    input  logic [4:0]       in_sel_start,
    input  logic [4:0]       in_len,
    output logic [4:0]       sel,
    output logic [WIDTH-1:0] data_a,
    output logic [WIDTH-1:0] data_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             exp_pick_b
);

    state_e           state_q,     state_d;
    sel_t             sel_q,       sel_d;
    beat_cnt_t        rem_q,       rem_d;
    logic [WIDTH-1:0] data_a_q,    data_a_d;
    logic [WIDTH-1:0] data_b_q,    data_b_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q,  out_last_d;

    // Next-state logic: capture in IDLE, advance or hold the burst in RUN.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        rem_d       = rem_q;
        data_a_d    = data_a_q;
        data_b_d    = data_b_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d     = ST_RUN;
                    sel_d       = in_sel_start;
                    rem_d       = in_len;
                    data_a_d    = in_data_a;
                    data_b_d    = in_data_b;
                    out_valid_d = 1'b1;
                    out_last_d  = (in_len == 5'd0);
                end else begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
            end
            ST_RUN: begin
                // A stall leaves every beat register untouched.
                if (out_ready) begin
                    if (rem_q == 5'd0) begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        sel_d      = sel_q + 5'd1;
                        rem_d      = rem_q - 5'd1;
                        out_last_d = (rem_q == 5'd1);
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset; reset aborts any burst in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= 5'd0;
            rem_q       <= 5'd0;
            data_a_q    <= {WIDTH{1'b0}};
            data_b_q    <= {WIDTH{1'b0}};
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            rem_q       <= rem_d;
            data_a_q    <= data_a_d;
            data_b_q    <= data_b_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE) && !rst;
    assign exp_pick_b = pick_b(sel_q);
    assign sel        = sel_q;
    assign data_a     = data_a_q;
    assign data_b     = data_b_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;

endmodule

// File: doc/paritysel_seq.md
PARITYSEL_SEQ -- requirements
Module: paritysel_seq

Interface
REQ-001 Parameter WIDTH, default 8: bit width of each data operand.
REQ-002 Port clk, input, 1 bit: the only clock; all logic is rising-edge triggered.
REQ-003 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port in_valid, input, 1 bit: a burst request is present on the in_* ports.
REQ-005 Port in_ready, output, 1 bit: the block can accept a burst request.
REQ-006 Port in_data_a, input, WIDTH bits: operand A for the burst.
REQ-007 Port in_data_b, input, WIDTH bits: operand B for the burst.
REQ-008 Port in_sel_start, input, 5 bits: sel value for the first beat.
REQ-009 Port in_len, input, 5 bits: beat count minus one, so bursts are 1..32 beats.
REQ-010 Port sel, output, 5 bits: select value for the downstream parity-select mux.
REQ-011 Port data_a, output, WIDTH bits: registered operand A; data_b, output, WIDTH bits: registered operand B.
REQ-012 Port out_valid, output, 1 bit: the current beat (sel, data_a, data_b) is valid.
REQ-013 Port out_ready, input, 1 bit: the consumer accepts the current beat.
REQ-014 Port out_last, output, 1 bit: the current beat is the final beat of the burst.
REQ-015 Port exp_pick_b, output, 1 bit: equals sel[0]; 1 means the mux must output data_b, 0 means data_a.

Function
REQ-016 The FSM SHALL have two states: IDLE and RUN.
REQ-017 IDLE: in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-018 IDLE with in_valid=1: the block SHALL capture in_data_a, in_data_b, in_sel_start and in_len, and SHALL enter RUN on the next edge.
REQ-019 Latency: the first beat SHALL be presented with out_valid=1 in the cycle after acceptance, with sel=in_sel_start.
REQ-020 RUN: in_ready SHALL be 0; in_valid SHALL be ignored and no request is queued.
REQ-021 A beat transfers on any edge where out_valid=1 and out_ready=1.
REQ-022 out_valid=1 and out_ready=0 (stall): sel, data_a, data_b, out_last and the remaining-beat count SHALL hold.
REQ-023 Transfer with remaining count nonzero: sel SHALL increment by 1 modulo 32 (31 wraps to 0), and the remaining count SHALL decrement by 1.
REQ-024 out_last SHALL be 1 exactly when the block is in RUN and the remaining count is 0.
REQ-025 Transfer of the last beat: the FSM SHALL return to IDLE, with out_valid=0 and in_ready=1 in the next cycle.
REQ-026 No back-to-back overlap: a new request SHALL be accepted no earlier than the first IDLE cycle after the last beat.
REQ-027 data_a and data_b SHALL change only on request acceptance or on reset.
REQ-028 in_len=31 SHALL produce exactly 32 beats; in_len=0 SHALL produce exactly 1 beat, with out_last=1 on that beat.

Reset
REQ-029 rst=1 at an edge SHALL force IDLE, sel=0, data_a=0, data_b=0, remaining count=0, out_valid=0 and out_last=0.
REQ-030 in_ready SHALL be 0 while rst=1.
REQ-031 Reset during RUN SHALL abort the burst with no further beats; the partially sent burst is not resumed.
REQ-032 rst and in_valid asserted together: rst SHALL win, and the request SHALL NOT be captured.

Structure
REQ-033 Package paritysel_pkg SHALL hold the SEL_W=5 constant, the FSM state enum type and the beat-count type.
REQ-034 The block SHALL be one module with no sub-modules; the sel counter and beat counter are inline registers.
REQ-035 Outputs sel, data_a, data_b, out_valid and out_last SHALL be driven directly from registers; in_ready and exp_pick_b MAY be combinational from registers.

Verification
REQ-036 Single beat: a=0x55, b=0xAA, start=2, len=0, out_ready=1 -> exactly one beat with sel=2, out_last=1, exp_pick_b=0; IDLE on the next cycle.
REQ-037 Odd start: start=3, len=3, out_ready=1 -> sel sequence 3,4,5,6 on consecutive cycles; exp_pick_b sequence 1,0,1,0; out_last only on sel=6.
REQ-038 Wrap-around: start=30, len=3 -> sel sequence 30,31,0,1, with no extra or missing beats.
REQ-039 Back-pressure: start=0, len=1, out_ready low for 3 cycles on beat 0 -> sel=0 held stable for 4 cycles, then sel=1; only 2 beats total.
REQ-040 Reset mid-burst: start=5, len=10, rst pulsed after 4 beats -> the next cycle shows out_valid=0, sel=0, data_a=data_b=0, and in_ready=1 once rst drops.
REQ-041 Request during RUN: in_valid held high with new operands through a burst -> in_ready stays 0, the running burst is unchanged, and the new request is accepted on the first IDLE cycle.
